// File: rtl/seg7_decoder_if.sv
// Seven-segment decoder bus: the raw segment input and the decoded result outputs.
interface seg7_decoder_if;
  logic [7:0] seg7;
  logic [3:0] digit;
  logic       digit_valid;
  logic       code_err;
  logic       seq_err;
  logic [7:0] digit_cnt;

  // Drives the segment bus and observes the decoded results.
  modport master (
    output seg7,
    input  digit, digit_valid, code_err, seq_err, digit_cnt
  );

  // The decoder itself.
  modport slave (
    input  seg7,
    output digit, digit_valid, code_err, seq_err, digit_cnt
  );
endinterface

// File: rtl/seg7_decoder.sv
// Debounced seven-segment glyph decoder.
// A code must be sampled STABLE_CYCLES times in a row before it is accepted.
// An illegal stable code raises code_err, and a legal new code raises digit_valid.
// Optional macro SEG7_SEQ_CHECK_EN adds a check that each accepted digit equals
// the previous digit plus one, modulo 16.
module seg7_decoder #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  seg7_decoder_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TGT =
    CNT_W'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic             acc_q, acc_d;
`ifdef SEG7_SEQ_CHECK_EN
  logic             seq_q, seq_d;
`endif

  logic [6:0] seg_in;
  logic       change;
  logic       hit;
  logic [4:0] dec;
  logic       dp_unused;

  // The decimal point does not take part in decoding.
  assign dp_unused = bus.seg7[7];
  assign seg_in    = bus.seg7[6:0];

  // Glyph lookup. Bit 4 is the legal flag and bits 3:0 hold the hex value.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign dec = decode(seg_in);

  // Next state, stability counting and acceptance decisions.
  always_comb begin
    state_d  = state_q;
    sample_d = seg_in;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    digit_d  = digit_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    dcnt_d   = dcnt_q;
    acc_d    = acc_q;
`ifdef SEG7_SEQ_CHECK_EN
    seq_d    = 1'b0;
`endif
    change   = (seg_in != sample_q);
    hit      = 1'b0;

    case (state_q)
      WAIT, LOCK: begin
        if (change) begin
          cnt_d = '0;
          if (STABLE_CYCLES <= 1) hit = 1'b1;
          else                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (change) cnt_d = '0;
        else if (cnt_q == CNT_TGT) hit = 1'b1;
      end
      default: state_d = WAIT;
    endcase

    if (hit) begin
      state_d = LOCK;
      if (!dec[4]) begin
        err_d = 1'b1;
      end else if (!acc_q || (dec[3:0] != digit_q)) begin
        digit_d = dec[3:0];
        valid_d = 1'b1;
        dcnt_d  = dcnt_q + 8'd1;
        acc_d   = 1'b1;
`ifdef SEG7_SEQ_CHECK_EN
        if (acc_q && (dec[3:0] != 4'(digit_q + 4'd1))) seq_d = 1'b1;
`endif
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT;
      sample_q <= '0;
      cnt_q    <= '0;
      digit_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      dcnt_q   <= '0;
      acc_q    <= 1'b0;
`ifdef SEG7_SEQ_CHECK_EN
      seq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      dcnt_q   <= dcnt_d;
      acc_q    <= acc_d;
`ifdef SEG7_SEQ_CHECK_EN
      seq_q    <= seq_d;
`endif
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.code_err    = err_q;
  assign bus.digit_cnt   = dcnt_q;
`ifdef SEG7_SEQ_CHECK_EN
  assign bus.seq_err     = seq_q;
`else
  assign bus.seq_err     = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder with STABLE_CYCLES=2.
module tb_seg7_decoder;

  localparam int unsigned STABLE = 2;

  logic clk;
  logic rst;

  seg7_decoder_if bus();

  seg7_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  int unsigned nv, ne, ns, nsv, nboth, first_v, first_e;
  logic [7:0] glyph [16];
  int unsigned exp_seq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a code just after a falling edge and observe it for the given number of cycles.
  task automatic hold(input logic [7:0] code, input int unsigned cycles);
    bus.seg7 = code;
    nv = 0; ne = 0; ns = 0; nsv = 0; first_v = 0; first_e = 0;
    for (int i = 1; i <= int'(cycles); i++) begin
      @(negedge clk);
      if (bus.digit_valid) begin
        nv++;
        if (first_v == 0) first_v = i;
      end
      if (bus.code_err) begin
        ne++;
        if (first_e == 0) first_e = i;
      end
      if (bus.seq_err) ns++;
      if (bus.seq_err && bus.digit_valid) nsv++;
      if (bus.digit_valid && bus.code_err) nboth++;
    end
  endtask

  initial begin
    glyph = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
`ifdef SEG7_SEQ_CHECK_EN
    exp_seq = 1;
`else
    exp_seq = 0;
`endif
    nboth = 0;
    rst = 1'b1;
    bus.seg7 = 8'h3F;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_digit", 32'(bus.digit), 32'h0);
    check("rst_valid", 32'(bus.digit_valid), 32'h0);
    check("rst_err", 32'(bus.code_err), 32'h0);
    check("rst_seq", 32'(bus.seq_err), 32'h0);
    check("rst_cnt", 32'(bus.digit_cnt), 32'h0);
    rst = 1'b1;

    // First code after reset, held five cycles.
    hold(8'h3F, 5);
    check("s0_pulses", nv, 1);
    check("s0_latency", first_v, STABLE);
    check("s0_digit", 32'(bus.digit), 32'h0);
    check("s0_cnt", 32'(bus.digit_cnt), 32'h1);
    check("s0_seq", ns, 0);

    // Accept 1, then a one-cycle glitch to 2, then back to 1.
    hold(8'h06, 4);
    check("s1_pulses", nv, 1);
    check("s1_digit", 32'(bus.digit), 32'h1);
    hold(8'h5B, 1);
    check("glitch_pulses", nv + ne, 0);
    hold(8'h06, 4);
    check("glitch_back_pulses", nv + ne, 0);
    check("glitch_digit", 32'(bus.digit), 32'h1);
    check("glitch_cnt", 32'(bus.digit_cnt), 32'h2);

    // Illegal blank code, then held for a long time while locked.
    hold(8'h00, 30);
    check("illegal_err", ne, 1);
    check("illegal_latency", first_e, STABLE);
    check("illegal_valid", nv, 0);
    check("illegal_digit", 32'(bus.digit), 32'h1);
    check("illegal_cnt", 32'(bus.digit_cnt), 32'h2);

    // Returning to the last accepted glyph after an illegal code produces nothing.
    hold(8'h06, 4);
    check("return_pulses", nv + ne, 0);

    // The decimal point is ignored. Going from 1 to 0 breaks the +1 sequence.
    hold(8'hBF, 4);
    check("dp_valid", nv, 1);
    check("dp_digit", 32'(bus.digit), 32'h0);
    check("dp_cnt", 32'(bus.digit_cnt), 32'h3);
    check("dp_seq", ns, exp_seq);

    // Assert reset one cycle into settling on 4.
    hold(8'h66, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.digit_valid), 32'h0);
    check("midrst_cnt", 32'(bus.digit_cnt), 32'h0);
    rst = 1'b1;
    hold(8'h66, 4);
    check("postrst_valid", nv, 1);
    check("postrst_latency", first_v, STABLE);
    check("postrst_digit", 32'(bus.digit), 32'h4);
    check("postrst_cnt", 32'(bus.digit_cnt), 32'h1);
    check("postrst_seq", ns, 0);

    // Walk 5,6,..,F,0,1.. for 255 more accepts so the count wraps to zero.
    begin
      int unsigned tot_v, tot_s;
      tot_v = 0; tot_s = 0;
      for (int i = 0; i < 255; i++) begin
        hold(glyph[(5 + i) % 16], 2);
        tot_v += nv;
        tot_s += ns;
        if (i == 253) check("wrap_cnt255", 32'(bus.digit_cnt), 32'hFF);
      end
      check("wrap_pulses", tot_v, 255);
      check("wrap_seq", tot_s, 0);
      check("wrap_cnt", 32'(bus.digit_cnt), 32'h0);
      check("wrap_digit", 32'(bus.digit), 32'h3);
    end

    // Sequence check: 3 -> 2 breaks it, 2 -> 3 is fine, 3 -> 5 breaks it.
    hold(8'h5B, 3);
    check("seq_2_valid", nv, 1);
    check("seq_2_err", ns, exp_seq);
    hold(8'h4F, 3);
    check("seq_3_valid", nv, 1);
    check("seq_3_err", ns, 0);
    hold(8'h6D, 3);
    check("seq_5_valid", nv, 1);
    check("seq_5_err", ns, exp_seq);
    check("seq_5_same_cycle", nsv, exp_seq);
    check("seq_5_digit", 32'(bus.digit), 32'h5);
    check("seq_5_cnt", 32'(bus.digit_cnt), 32'h3);

    check("valid_err_overlap", nboth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, is the number of consecutive identical rising-edge samples required to accept a segment code (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 seg7  input  8  segment bus {dp,g,f,e,d,c,b,a}, active-high; dp is ignored.
REQ-005 digit  output  4  last accepted hex value.
REQ-006 digit_valid  output  1  one-cycle pulse when a new code is accepted.
REQ-007 code_err  output  1  one-cycle pulse when a stable code is not a legal hex glyph.
REQ-008 seq_err  output  1  one-cycle pulse on a sequence violation (see Configuration).
REQ-009 digit_cnt  output  8  number of accepted digits, modulo 256.

Function
REQ-010 Legal glyphs on seg7[6:0] SHALL decode to hex values as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71; every other pattern is illegal.
REQ-011 The block SHALL register seg7[6:0] each cycle and keep a saturating match counter; the counter clears on any sampled change and increments while samples are equal.
REQ-012 The FSM SHALL have three states: WAIT (no code accepted since reset), SETTLE (sample changed, counting) and LOCK (current code accepted or rejected).
REQ-013 Transitions: WAIT/LOCK->SETTLE on a sampled change; SETTLE->LOCK when STABLE_CYCLES equal samples are reached; SETTLE->SETTLE (counter cleared) on a further change.
REQ-014 Latency: with a code first sampled at edge k and held, digit_valid or code_err SHALL be asserted from edge k+STABLE_CYCLES-1 for exactly one cycle.
REQ-015 On entry to LOCK with a legal code that differs from the last accepted code, or with any legal code when leaving WAIT, the block SHALL update digit, pulse digit_valid, and increment digit_cnt.
REQ-016 On entry to LOCK with the same code as the last accepted code (a glitch returning to the old glyph), no output other than the FSM state SHALL change.
REQ-017 On entry to LOCK with an illegal code, the block SHALL pulse code_err and leave digit, digit_cnt and the last-accepted code unchanged.
REQ-018 The outputs digit_valid and code_err SHALL never both be high in the same cycle.
REQ-019 The counter digit_cnt SHALL wrap from 255 to 0 without any error indication.
REQ-020 While in LOCK with a steady input, no pulses SHALL be generated, regardless of how long the input is held.

Reset
REQ-021 While rst=0, the following SHALL hold: digit=0, digit_valid=0, code_err=0, seq_err=0, digit_cnt=0, FSM in WAIT, match counter=0, sample register=0, and no last-accepted code.
REQ-022 A reset asserted mid-SETTLE SHALL abort acceptance, with no pulse emitted, and the first code after release SHALL be treated as the first after reset.

Configuration
REQ-023 Macro SEG7_SEQ_CHECK_EN: when defined, each accepted digit (except the first after reset) SHALL be checked to equal previous+1 modulo 16, and on mismatch seq_err SHALL pulse in the same cycle as digit_valid, with digit still updated.
REQ-024 Without SEG7_SEQ_CHECK_EN, seq_err SHALL be tied to 0 and no comparison logic SHALL be present.

Verification
REQ-025 Scenario: reset, then seg7=0x3F held 5 cycles (STABLE_CYCLES=2) -> one digit_valid pulse, digit=0, digit_cnt=1.
REQ-026 Scenario: 0x06 held, then 0x5B for 1 cycle, then back to 0x06 -> no new pulse, digit stays 1.
REQ-027 Scenario: stable 0x00 -> code_err pulses once; digit and digit_cnt are unchanged.
REQ-028 Scenario: glyphs for 0..F then 0, repeated to 256 accepts -> digit_cnt wraps to 0; with SEG7_SEQ_CHECK_EN, seq_err stays 0.
REQ-029 Scenario with SEG7_SEQ_CHECK_EN: accept 3 (0x4F), then 5 (0x6D) -> seq_err and digit_valid pulse together, digit=5.
REQ-030 Scenario: rst driven low one cycle into SETTLE on 0x66 -> no digit_valid; after release, 0x66 is accepted as the first digit with digit_cnt=1.
